// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding,
// special instruction encodings and the IF/ID pipeline register payload.
package fetch_unit_pkg;

   typedef logic [0:0] fetch_state_t;
   localparam fetch_state_t RUN  = 1'b0;
   localparam fetch_state_t HALT = 1'b1;

   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INST_FENCE  = 32'h0000_000F;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic        valid;
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] pc4;
   } if_id_t;

   function automatic logic is_halt_inst(input logic [31:0] inst);
      return (inst == INST_ECALL) || (inst == INST_EBREAK);
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory bus between the fetch stage (master) and the
// combinational-read instruction memory (slave).
interface fetch_unit_if #(parameter int IMEM_AW = 6);

   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_data;

   modport master (output imem_addr, input imem_data);
   modport slave  (input imem_addr, output imem_data);

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register. Flush only drops the valid bit so the payload
// of a squashed slot stays visible for debug.
module if_id_reg
   import fetch_unit_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   load,
   input  logic   flush,
   input  if_id_t data,
   output if_id_t q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (flush) begin
         q.valid <= 1'b0;
      end else if (load) begin
         q <= data;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, RUN/HALT FSM and fetch counter feeding the
// IF/ID register. Redirects beat stalls, stalls beat normal fetch.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          IMEM_AW  = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   fetch_unit_if.master       imem,
   input  logic               stall,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   output logic               if_id_valid,
   output logic [31:0]        if_id_inst,
   output logic [31:0]        if_id_pc,
   output logic [31:0]        if_id_pc4,
   output logic               halted,
   output logic [31:0]        fetch_count
);

   logic [31:0]  pc;
   logic [31:0]  pc_plus4;
   fetch_state_t state;
   logic         fetch_fire;
   logic         flush;
   logic         redirect_lsb_unused;
   if_id_t       if_id_d;
   if_id_t       if_id_q;

   assign pc_plus4            = pc + 32'd4;
   assign imem.imem_addr      = pc[IMEM_AW+1:2];
   assign redirect_lsb_unused = ^redirect_pc[1:0];

   assign fetch_fire = !redirect_valid && !stall && (state == RUN);
   // A halted, unstalled stage keeps emitting bubbles so the last
   // delivered instruction is not seen twice downstream.
   assign flush      = redirect_valid || (!stall && (state == HALT));

   always_comb begin
      if_id_d       = '0;
      if_id_d.valid = 1'b1;
      if_id_d.inst  = imem.imem_data;
      if_id_d.pc    = pc;
      if_id_d.pc4   = pc_plus4;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         state       <= RUN;
         fetch_count <= '0;
      end else if (redirect_valid) begin
         pc    <= {redirect_pc[31:2], 2'b00};
         state <= RUN;
      end else if (fetch_fire) begin
         pc          <= pc_plus4;
         fetch_count <= fetch_count + 32'd1;
         if (is_halt_inst(imem.imem_data)) begin
            state <= HALT;
         end
      end
   end

   if_id_reg u_if_id_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (fetch_fire),
      .flush (flush),
      .data  (if_id_d),
      .q     (if_id_q)
   );

   assign if_id_valid = if_id_q.valid;
   assign if_id_inst  = if_id_q.inst;
   assign if_id_pc    = if_id_q.pc;
   assign if_id_pc4   = if_id_q.pc4;
   assign halted      = (state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit against a small instruction memory image.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_id_valid;
   logic [31:0] if_id_inst;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc4;
   logic        halted;
   logic [31:0] fetch_count;
   logic [31:0] mem [64];
   int          checks = 0;
   int          errors = 0;

   fetch_unit_if #(.IMEM_AW(6)) imem ();

   assign imem.imem_data = mem[imem.imem_addr];

   fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(6)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem           (imem),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_id_valid    (if_id_valid),
      .if_id_inst     (if_id_inst),
      .if_id_pc       (if_id_pc),
      .if_id_pc4      (if_id_pc4),
      .halted         (halted),
      .fetch_count    (fetch_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      step();
      checks++; if (imem.imem_addr !== 6'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", imem.imem_addr); end
      checks++; if ({if_id_valid, if_id_inst, if_id_pc, if_id_pc4} !== '0) begin errors++; $display("FAIL reset_ifid got %h/%h/%h/%h want zero", if_id_valid, if_id_inst, if_id_pc, if_id_pc4); end
      checks++; if ({halted, fetch_count} !== '0) begin errors++; $display("FAIL reset_state got halted=%b cnt=%0d want 0/0", halted, fetch_count); end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      step();
      checks++; if ({if_id_valid, if_id_inst, if_id_pc} !== {1'b1, 32'h0000_0083, 32'h0}) begin errors++; $display("FAIL first_fetch got %b/%h/%h want 1/00000083/0", if_id_valid, if_id_inst, if_id_pc); end
      step();
      checks++; if ({if_id_inst, if_id_pc, if_id_pc4} !== {32'h0010_0103, 32'h4, 32'h8}) begin errors++; $display("FAIL second_fetch got %h/%h/%h want 00100103/4/8", if_id_inst, if_id_pc, if_id_pc4); end
      checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL count2 got %0d want 2", fetch_count); end
      step(); step();
      checks++; if ({imem.imem_addr, if_id_pc, fetch_count} !== {6'd4, 32'hC, 32'd4}) begin errors++; $display("FAIL at_pc10 got addr=%0d pc=%h cnt=%0d want 4/c/4", imem.imem_addr, if_id_pc, fetch_count); end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if ({imem.imem_addr, if_id_valid, if_id_pc, if_id_inst, fetch_count} !== {6'd4, 1'b1, 32'hC, NOP, 32'd4}) begin errors++; $display("FAIL stall_hold%0d got addr=%0d v=%b pc=%h inst=%h cnt=%0d want 4/1/c/00000013/4", i, imem.imem_addr, if_id_valid, if_id_pc, if_id_inst, fetch_count); end
      end
      stall = 1'b0;
      step();
      checks++; if ({imem.imem_addr, if_id_pc, fetch_count} !== {6'd5, 32'h10, 32'd5}) begin errors++; $display("FAIL stall_resume got addr=%0d pc=%h cnt=%0d want 5/10/5", imem.imem_addr, if_id_pc, fetch_count); end
   endtask

   task automatic test_redirect();
      stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h47;
      step();
      stall = 1'b0; redirect_valid = 1'b0;
      checks++; if ({imem.imem_addr, if_id_valid, fetch_count} !== {6'd17, 1'b0, 32'd5}) begin errors++; $display("FAIL redirect got addr=%0d v=%b cnt=%0d want 17/0/5", imem.imem_addr, if_id_valid, fetch_count); end
      step();
      checks++; if ({if_id_valid, if_id_pc, if_id_pc4, fetch_count} !== {1'b1, 32'h44, 32'h48, 32'd6}) begin errors++; $display("FAIL redirect_fetch got v=%b pc=%h pc4=%h cnt=%0d want 1/44/48/6", if_id_valid, if_id_pc, if_id_pc4, fetch_count); end
   endtask

   task automatic test_halt();
      redirect_valid = 1'b1; redirect_pc = 32'h20;
      step();
      redirect_valid = 1'b0;
      step();
      checks++; if ({if_id_valid, if_id_inst, if_id_pc, halted} !== {1'b1, 32'h0010_0073, 32'h20, 1'b1}) begin errors++; $display("FAIL halt_fetch got v=%b inst=%h pc=%h halted=%b want 1/00100073/20/1", if_id_valid, if_id_inst, if_id_pc, halted); end
      step();
      checks++; if ({halted, if_id_valid, imem.imem_addr, fetch_count} !== {1'b1, 1'b0, 6'd9, 32'd7}) begin errors++; $display("FAIL halt_hold got h=%b v=%b addr=%0d cnt=%0d want 1/0/9/7", halted, if_id_valid, imem.imem_addr, fetch_count); end
      step();
      checks++; if ({halted, if_id_valid, imem.imem_addr, fetch_count} !== {1'b1, 1'b0, 6'd9, 32'd7}) begin errors++; $display("FAIL halt_hold2 got h=%b v=%b addr=%0d cnt=%0d want 1/0/9/7", halted, if_id_valid, imem.imem_addr, fetch_count); end
      redirect_valid = 1'b1; redirect_pc = 32'h0;
      step();
      redirect_valid = 1'b0;
      checks++; if ({halted, if_id_valid, imem.imem_addr} !== {1'b0, 1'b0, 6'd0}) begin errors++; $display("FAIL halt_exit got h=%b v=%b addr=%0d want 0/0/0", halted, if_id_valid, imem.imem_addr); end
      step();
      checks++; if ({if_id_valid, if_id_inst, if_id_pc, fetch_count} !== {1'b1, 32'h0000_0083, 32'h0, 32'd8}) begin errors++; $display("FAIL halt_restart got v=%b inst=%h pc=%h cnt=%0d want 1/00000083/0/8", if_id_valid, if_id_inst, if_id_pc, fetch_count); end
   endtask

   task automatic test_wrap();
      redirect_valid = 1'b1; redirect_pc = 32'hFC;
      step();
      redirect_valid = 1'b0;
      checks++; if (imem.imem_addr !== 6'd63) begin errors++; $display("FAIL wrap_addr63 got %0d want 63", imem.imem_addr); end
      step();
      checks++; if ({imem.imem_addr, if_id_pc, if_id_pc4} !== {6'd0, 32'hFC, 32'h100}) begin errors++; $display("FAIL wrap_addr0 got addr=%0d pc=%h pc4=%h want 0/fc/100", imem.imem_addr, if_id_pc, if_id_pc4); end
      checks++; if ({if_id_valid, if_id_inst, halted} !== {1'b1, 32'h0000_000F, 1'b0}) begin errors++; $display("FAIL fence_fetch got v=%b inst=%h h=%b want 1/0000000f/0", if_id_valid, if_id_inst, halted); end
   endtask

   task automatic test_reset_in_halt();
      redirect_valid = 1'b1; redirect_pc = 32'h20;
      step();
      redirect_valid = 1'b0;
      step();
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL prehalt got %b want 1", halted); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({if_id_valid, if_id_inst, if_id_pc, if_id_pc4, halted, fetch_count} !== '0) begin errors++; $display("FAIL async_reset got v=%b inst=%h pc=%h pc4=%h h=%b cnt=%0d want zeros", if_id_valid, if_id_inst, if_id_pc, if_id_pc4, halted, fetch_count); end
      checks++; if (imem.imem_addr !== 6'd0) begin errors++; $display("FAIL async_reset_addr got %0d want 0", imem.imem_addr); end
      #2 rst_n = 1'b1;
      step();
      checks++; if ({if_id_valid, if_id_inst, if_id_pc, fetch_count, halted} !== {1'b1, 32'h0000_0083, 32'h0, 32'd1, 1'b0}) begin errors++; $display("FAIL post_reset_fetch got v=%b inst=%h pc=%h cnt=%0d h=%b want 1/00000083/0/1/0", if_id_valid, if_id_inst, if_id_pc, fetch_count, halted); end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = NOP;
      mem[0]  = 32'h0000_0083;
      mem[1]  = 32'h0010_0103;
      mem[8]  = 32'h0010_0073;
      mem[63] = 32'h0000_000F;
      test_reset();
      test_basic();
      test_stall();
      test_redirect();
      test_halt();
      test_wrap();
      test_reset_in_halt();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded at reset (word aligned).
REQ-002 SHALL have parameter IMEM_AW, default 6, meaning the instruction-memory word-address width.
REQ-003 SHALL have port clk  input  1  meaning the single rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  meaning the reset; reset is asynchronous and active-low.
REQ-005 SHALL have port imem_addr  output  IMEM_AW  meaning the word address to instruction memory, equal to pc[IMEM_AW+1:2].
REQ-006 SHALL have port imem_data  input  32  meaning the combinational read data for imem_addr.
REQ-007 SHALL have port stall  input  1  meaning hold PC and the IF/ID register.
REQ-008 SHALL have port redirect_valid  input  1  meaning a branch, jump or trap target is present this cycle.
REQ-009 SHALL have port redirect_pc  input  32  meaning the target PC.
REQ-010 SHALL have port if_id_valid  output  1  meaning the IF/ID register holds a real instruction.
REQ-011 SHALL have port if_id_inst  output  32  meaning the registered instruction.
REQ-012 SHALL have port if_id_pc  output  32  meaning the PC of if_id_inst.
REQ-013 SHALL have port if_id_pc4  output  32  meaning if_id_pc + 4.
REQ-014 SHALL have port halted  output  1  meaning the FSM is in HALT.
REQ-015 SHALL have port fetch_count  output  32  meaning the number of instructions delivered to IF/ID.

Function
REQ-016 SHALL hold a 32-bit pc register; imem_addr SHALL be combinational from pc (zero latency); the instruction appears on if_id_inst one clock after its address.
REQ-017 SHALL apply update priority per edge: reset > redirect_valid > stall > normal.
REQ-018 Normal in RUN: pc <= pc+4; IF/ID <= {valid=1, imem_data, pc, pc+4}; fetch_count += 1.
REQ-019 stall=1 without redirect: pc, IF/ID, fetch_count and state SHALL hold unchanged.
REQ-020 redirect_valid=1: pc <= {redirect_pc[31:2],2'b00}; if_id_valid <= 0 (flush); state <= RUN; this overrides a simultaneous stall.
REQ-021 FSM states SHALL be RUN and HALT; RUN->HALT when a non-stalled, non-redirected fetch captures imem_data equal to 32'h0000_0073 (ECALL) or 32'h0010_0073 (EBREAK); that instruction SHALL still be delivered valid.
REQ-022 In HALT: pc SHALL hold; if not stalled, if_id_valid <= 0 and fetch_count holds; only redirect_valid SHALL leave HALT.
REQ-023 FENCE (32'h0000_000F) and all other encodings SHALL be fetched as ordinary instructions.
REQ-024 pc arithmetic SHALL be modulo 2^32; imem_addr SHALL wrap modulo 2^IMEM_AW (pc 0xFC -> 0x100 gives imem_addr 63 -> 0).
REQ-025 fetch_count SHALL wrap from 0xFFFF_FFFF to 0.
REQ-026 halted SHALL be registered state, asserted in the cycle after the halting fetch.

Reset
REQ-027 rst_n low SHALL asynchronously set pc=RESET_PC, state=RUN, if_id_valid=0, if_id_inst=0, if_id_pc=0, if_id_pc4=0, halted=0, fetch_count=0.
REQ-028 Reset asserted mid-operation (including during stall or HALT) SHALL discard all in-flight state; the first fetch after deassertion SHALL be from RESET_PC.

Structure
REQ-029 The shared package SHALL hold the FSM state type {RUN, HALT}, the ECALL/EBREAK/FENCE encoding constants and the RESET_PC default.
REQ-030 The IF/ID register SHALL be a sub-module if_id_reg (inputs: load, flush, data; asynchronous active-low reset); PC logic and FSM SHALL stay in fetch_unit.

Verification
REQ-031 Reset release, memory word0=0x00000083, word1=0x00100103 -> cycle 1: if_id_inst=0x00000083, if_id_pc=0; cycle 2: if_id_inst=0x00100103, if_id_pc=4, if_id_pc4=8, fetch_count=2.
REQ-032 stall high 3 cycles at pc=0x10 -> pc, if_id_* and fetch_count unchanged for all 3 cycles; resumes with pc=0x14.
REQ-033 redirect_valid with redirect_pc=0x47, together with stall=1 -> next cycle pc=0x44, imem_addr=17, if_id_valid=0; following cycle if_id_pc=0x44.
REQ-034 word8=0x00100073 fetched at pc=0x20 -> if_id_inst=0x00100073 valid; next cycle halted=1, if_id_valid=0, pc held at 0x24; redirect to 0x0 -> halted=0, fetch restarts at 0.
REQ-035 pc=0xFC -> imem_addr=63, next pc=0x100 with imem_addr=0.
REQ-036 rst_n pulsed low asynchronously mid-cycle while in HALT -> all outputs at reset values immediately, next fetch from RESET_PC.
